// File: rtl/wb_gpio_pkg.sv
// Shared definitions for the Wishbone GPIO bank: register indices, edge polarity
// encoding and the byte-lane mask helper.
package wb_gpio_pkg;

   typedef enum logic [2:0] {
      REG_OUT      = 3'd0,
      REG_OE       = 3'd1,
      REG_IN       = 3'd2,
      REG_IRQ_EN   = 3'd3,
      REG_IRQ_STAT = 3'd4,
      REG_EDGE     = 3'd5,
      REG_SET      = 3'd6,
      REG_CLR      = 3'd7
   } reg_idx_e;

   localparam logic EDGE_RISING  = 1'b1;
   localparam logic EDGE_FALLING = 1'b0;

   function automatic logic [31:0] lane_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-pin debounce: the output follows the input only after the input has held
// a new value for DEB_CYCLES consecutive cycles.
module gpio_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   localparam logic [7:0] LAST_CNT = 8'(DEB_CYCLES - 1);

   logic [7:0] cnt_r;
   logic       dout_r;

   // Count consecutive cycles of disagreement; any return to the held value restarts.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r  <= 8'd0;
         dout_r <= 1'b0;
      end else if (din == dout_r) begin
         cnt_r  <= 8'd0;
      end else if (cnt_r == LAST_CNT) begin
         cnt_r  <= 8'd0;
         dout_r <= din;
      end else begin
         cnt_r  <= cnt_r + 8'd1;
      end
   end

   assign dout = dout_r;

endmodule

// File: rtl/wb_gpio_bank.sv
// Wishbone classic GPIO bank with per-pin edge interrupts.
// Optional input debounce is enabled with macro GPIO_DEBOUNCE_EN.
module wb_gpio_bank
   import wb_gpio_pkg::*;
#(
   parameter int NPINS      = 16,
   parameter int DEB_CYCLES = 4
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_stb_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic [31:0]      wbs_dat_o,
   output logic             wbs_ack_o,
   input  logic [NPINS-1:0] io_in,
   output logic [NPINS-1:0] io_out,
   output logic [NPINS-1:0] io_oeb,
   output logic [2:0]       irq
);

   logic [NPINS-1:0] out_r, oe_r, irq_en_r, stat_r, edge_r;
   logic [NPINS-1:0] sync1_r, sync2_r, prev_r, in_s;
   logic [NPINS-1:0] lane_s, wdat_s, hit_s, w1c_s;
   logic [31:0]      lane32_s, rdat_s, dat_r;
   logic             ack_r, irq0_r, armed_r, req_s, wr_s;
   reg_idx_e         idx_s;
   logic             unused_s;

   assign req_s    = wbs_cyc_i & wbs_stb_i & ~ack_r;
   assign wr_s     = req_s & wbs_we_i;
   assign idx_s    = reg_idx_e'(wbs_adr_i[4:2]);
   assign lane32_s = lane_mask(wbs_sel_i);
   assign lane_s   = lane32_s[NPINS-1:0];
   assign wdat_s   = wbs_dat_i[NPINS-1:0];
   assign unused_s = ^{wbs_adr_i[31:5], wbs_adr_i[1:0], 8'(DEB_CYCLES)};

`ifdef GPIO_DEBOUNCE_EN
   for (genvar g = 0; g < NPINS; g++) begin : g_deb
      gpio_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .clk  (wb_clk_i),
         .rst  (wb_rst_i),
         .din  (sync2_r[g]),
         .dout (in_s[g])
      );
   end
`else
   assign in_s = sync2_r;
`endif

   // Read mux; unmapped pin bits zero-extend to 32.
   always_comb begin
      rdat_s = 32'd0;
      case (idx_s)
         REG_OUT:      rdat_s = 32'(out_r);
         REG_OE:       rdat_s = 32'(oe_r);
         REG_IN:       rdat_s = 32'(in_s);
         REG_IRQ_EN:   rdat_s = 32'(irq_en_r);
         REG_IRQ_STAT: rdat_s = 32'(stat_r);
         REG_EDGE:     rdat_s = 32'(edge_r);
         default:      rdat_s = 32'd0;
      endcase
   end

   // Edge detect against the previous IN, suppressed on the first cycle after reset.
   always_comb begin
      hit_s = '0;
      for (int i = 0; i < NPINS; i++) begin
         if (!armed_r) begin
            hit_s[i] = 1'b0;
         end else if (edge_r[i] == EDGE_RISING) begin
            hit_s[i] = in_s[i] & ~prev_r[i];
         end else begin
            hit_s[i] = ~in_s[i] & prev_r[i];
         end
      end
   end

   // Write-one-to-clear mask for IRQ_STAT.
   always_comb begin
      w1c_s = '0;
      if (wr_s && (idx_s == REG_IRQ_STAT)) begin
         w1c_s = wdat_s & lane_s;
      end else begin
         w1c_s = '0;
      end
   end

   // Bus handshake, register file, synchroniser and interrupt state.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         out_r    <= '0;
         oe_r     <= '0;
         irq_en_r <= '0;
         stat_r   <= '0;
         edge_r   <= '0;
         sync1_r  <= '0;
         sync2_r  <= '0;
         prev_r   <= '0;
         armed_r  <= 1'b0;
         ack_r    <= 1'b0;
         dat_r    <= 32'd0;
         irq0_r   <= 1'b0;
      end else begin
         sync1_r <= io_in;
         sync2_r <= sync1_r;
         prev_r  <= in_s;
         armed_r <= 1'b1;
         ack_r   <= req_s;
         dat_r   <= req_s ? rdat_s : 32'd0;
         if (wr_s) begin
            case (idx_s)
               REG_OUT:    out_r    <= (out_r & ~lane_s) | (wdat_s & lane_s);
               REG_OE:     oe_r     <= (oe_r & ~lane_s) | (wdat_s & lane_s);
               REG_IRQ_EN: irq_en_r <= (irq_en_r & ~lane_s) | (wdat_s & lane_s);
               REG_EDGE:   edge_r   <= (edge_r & ~lane_s) | (wdat_s & lane_s);
               REG_SET:    out_r    <= out_r | wdat_s;
               REG_CLR:    out_r    <= out_r & ~wdat_s;
               default:    ;
            endcase
         end
         // New edges win over a same-cycle clear.
         stat_r <= (stat_r & ~w1c_s) | hit_s;
         irq0_r <= |(stat_r & irq_en_r);
      end
   end

   assign wbs_ack_o = ack_r;
   assign wbs_dat_o = dat_r;
   assign io_out    = out_r;
   assign io_oeb    = ~oe_r;
   assign irq       = {2'b00, irq0_r};

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Self-checking bench for wb_gpio_bank: register vector table plus hand-written
// sequences for interrupts, handshake, reset abort and (with the macro) debounce.
module tb_wb_gpio_bank;
   import wb_gpio_pkg::*;

   localparam int DEB = 4;
`ifdef GPIO_DEBOUNCE_EN
   localparam int IN_LAT = 2 + DEB;
`else
   localparam int IN_LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we_i = 1'b0;
   logic [3:0]  sel_i = 4'h0;
   logic [31:0] adr = 32'd0, dat_i = 32'd0, dat_o;
   logic        ack;
   logic [15:0] io_in = 16'h0000, io_out, io_oeb;
   logic [2:0]  irq;

   int checks = 0;
   int errors = 0;

   wb_gpio_bank #(.NPINS(16), .DEB_CYCLES(DEB)) dut (
      .wb_clk_i (clk),      .wb_rst_i (rst),
      .wbs_cyc_i(cyc),      .wbs_stb_i(stb),      .wbs_we_i (we_i),
      .wbs_sel_i(sel_i),    .wbs_adr_i(adr),      .wbs_dat_i(dat_i),
      .wbs_dat_o(dat_o),    .wbs_ack_o(ack),
      .io_in    (io_in),    .io_out   (io_out),   .io_oeb   (io_oeb),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic xfer(input logic we, input logic [2:0] idx, input logic [31:0] dat,
                       input logic [3:0] sel, output logic [31:0] rdat, output int lat);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we_i = we;
      adr = {27'd0, idx, 2'b00}; dat_i = dat; sel_i = sel;
      lat = 0;
      do begin
         @(posedge clk); #1; lat++;
      end while (!ack && lat < 8);
      if (!ack) begin
         checks++; errors++;
         $display("FAIL ack_timeout: got no ack after %0d cycles, required ack", lat);
      end
      rdat = dat_o;
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] dat, input logic [3:0] sel);
      logic [31:0] r;
      int l;
      xfer(1'b1, idx, dat, sel, r, l);
   endtask

   task automatic rd_chk(input string name, input logic [2:0] idx, input logic [31:0] exp);
      logic [31:0] r;
      int l;
      xfer(1'b0, idx, 32'd0, 4'hF, r, l);
      chk(name, r, exp);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  idx;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        chk_rd;
      logic [31:0] exp;
      logic        chk_io;
      logic [15:0] exp_out;
      logic [15:0] exp_oeb;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic we, input logic [2:0] idx, input logic [31:0] dat,
                      input logic [3:0] sel, input logic chk_rd, input logic [31:0] exp,
                      input logic chk_io, input logic [15:0] eo, input logic [15:0] eb,
                      input string name);
      vec_t v;
      v = '{we, idx, dat, sel, chk_rd, exp, chk_io, eo, eb, name};
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] r;
      int          l;

      // Register-level vectors: {we, idx, data, sel, check read, expected, check pins, io_out, io_oeb}
      add(1'b0, REG_OUT,      32'h0,        4'hF, 1'b1, 32'h0,        1'b1, 16'h0000, 16'hFFFF, "rst_out");
      add(1'b0, REG_OE,       32'h0,        4'hF, 1'b1, 32'h0,        1'b0, 16'h0,    16'h0,    "rst_oe");
      add(1'b0, REG_IRQ_STAT, 32'h0,        4'hF, 1'b1, 32'h0,        1'b0, 16'h0,    16'h0,    "rst_stat");
      add(1'b1, REG_OUT,      32'h000000A5, 4'h3, 1'b0, 32'h0,        1'b1, 16'h00A5, 16'hFFFF, "wr_out");
      add(1'b0, REG_OUT,      32'h0,        4'hF, 1'b1, 32'h000000A5, 1'b1, 16'h00A5, 16'hFFFF, "rd_out");
      add(1'b1, REG_OE,       32'h000000FF, 4'hF, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "wr_oe");
      add(1'b1, REG_SET,      32'h00000100, 4'hF, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "set");
      add(1'b1, REG_CLR,      32'h00000001, 4'hF, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "clr");
      add(1'b0, REG_OUT,      32'h0,        4'hF, 1'b1, 32'h000001A4, 1'b1, 16'h01A4, 16'hFF00, "set_clr_out");
      add(1'b0, REG_OE,       32'h0,        4'hF, 1'b1, 32'h000000FF, 1'b0, 16'h0,    16'h0,    "rd_oe");
      add(1'b0, REG_SET,      32'h0,        4'hF, 1'b1, 32'h0,        1'b0, 16'h0,    16'h0,    "rd_set_zero");
      add(1'b0, REG_CLR,      32'h0,        4'hF, 1'b1, 32'h0,        1'b0, 16'h0,    16'h0,    "rd_clr_zero");
      add(1'b1, REG_OUT,      32'hFFFFFFFF, 4'h2, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "wr_lane1");
      add(1'b0, REG_OUT,      32'h0,        4'hF, 1'b1, 32'h0000FFA4, 1'b1, 16'hFFA4, 16'hFF00, "lane1_out");
      add(1'b1, REG_OE,       32'hFFFFFFFF, 4'hF, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "wr_oe_all");
      add(1'b0, REG_OE,       32'h0,        4'hF, 1'b1, 32'h0000FFFF, 1'b1, 16'hFFA4, 16'h0000, "oe_hi_bits");
      add(1'b1, REG_IN,       32'h00001234, 4'hF, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "wr_in");
      add(1'b0, REG_IN,       32'h0,        4'hF, 1'b1, 32'h0,        1'b0, 16'h0,    16'h0,    "in_noop");
      add(1'b1, REG_EDGE,     32'hFFFF0F0F, 4'hF, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "wr_edge");
      add(1'b0, REG_EDGE,     32'h0,        4'hF, 1'b1, 32'h00000F0F, 1'b0, 16'h0,    16'h0,    "rd_edge");
      add(1'b1, REG_IRQ_EN,   32'h00005A5A, 4'h1, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "wr_irq_en");
      add(1'b0, REG_IRQ_EN,   32'h0,        4'hF, 1'b1, 32'h0000005A, 1'b0, 16'h0,    16'h0,    "rd_irq_en");
      add(1'b0, REG_IRQ_STAT, 32'h0,        4'hF, 1'b1, 32'h0,        1'b0, 16'h0,    16'h0,    "stat_quiet");
      add(1'b1, REG_OE,       32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "clr_oe");
      add(1'b1, REG_OUT,      32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "clr_out");
      add(1'b1, REG_EDGE,     32'h0,        4'hF, 1'b0, 32'h0,        1'b0, 16'h0,    16'h0,    "clr_edge");
      add(1'b1, REG_IRQ_EN,   32'h0,        4'hF, 1'b0, 32'h0,        1'b1, 16'h0000, 16'hFFFF, "clr_irq_en");

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_dat_o", dat_o, 32'd0);
      chk("rst_io_out", {16'd0, io_out}, 32'h0000);
      chk("rst_io_oeb", {16'd0, io_oeb}, 32'h0000FFFF);
      chk("rst_irq", {29'd0, irq}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         xfer(vecs[i].we, vecs[i].idx, vecs[i].dat, vecs[i].sel, r, l);
         chk({vecs[i].name, "_ack_lat"}, l, 32'd1);
         if (vecs[i].chk_rd) chk(vecs[i].name, r, vecs[i].exp);
         if (vecs[i].chk_io) begin
            chk({vecs[i].name, "_io_out"}, {16'd0, io_out}, {16'd0, vecs[i].exp_out});
            chk({vecs[i].name, "_io_oeb"}, {16'd0, io_oeb}, {16'd0, vecs[i].exp_oeb});
         end
      end

      // Rising edge on pin 3 with interrupt enabled
      wr(REG_EDGE, 32'h8, 4'hF);
      wr(REG_IRQ_EN, 32'h8, 4'hF);
      @(negedge clk);
      io_in[3] = 1'b1;
      repeat (IN_LAT + 1) @(posedge clk);
      #1 chk("irq_not_yet", {29'd0, irq}, 32'd0);
      @(posedge clk);
      #1 chk("irq_rise", {29'd0, irq}, 32'd1);
      rd_chk("stat_pin3", REG_IRQ_STAT, 32'h8);
      rd_chk("in_pin3", REG_IN, 32'h8);
      wr(REG_IRQ_STAT, 32'h8, 4'hF);
      @(posedge clk);
      #1 chk("irq_cleared", {29'd0, irq}, 32'd0);
      rd_chk("stat_w1c", REG_IRQ_STAT, 32'h0);

      // Falling edge ignored on a rising-polarity pin
      @(negedge clk);
      io_in[3] = 1'b0;
      repeat (IN_LAT + 3) @(posedge clk);
      rd_chk("stat_fall_ignored", REG_IRQ_STAT, 32'h0);

      // Edge arrives in the same cycle as a w1c of the same bit
      @(negedge clk);
      io_in[3] = 1'b1;
      repeat (IN_LAT) @(posedge clk);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we_i = 1'b1;
      adr = {27'd0, REG_IRQ_STAT, 2'b00}; dat_i = 32'h8; sel_i = 4'hF;
      @(posedge clk);
      #1 chk("w1c_race_ack", {31'd0, ack}, 32'd1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
      rd_chk("set_beats_clear", REG_IRQ_STAT, 32'h8);

      // Falling edge on a pin with IRQ_EN clear: status sets, irq stays low
      wr(REG_IRQ_STAT, 32'hFFFF, 4'hF);
      @(negedge clk);
      io_in[5] = 1'b1;
      repeat (IN_LAT + 3) @(posedge clk);
      rd_chk("stat_rise_ignored", REG_IRQ_STAT, 32'h0);
      @(negedge clk);
      io_in[5] = 1'b0;
      repeat (IN_LAT + 3) @(posedge clk);
      rd_chk("stat_fall_pin5", REG_IRQ_STAT, 32'h20);
      chk("irq_masked", {29'd0, irq}, 32'd0);

      // Strobe held across the ack: ack must drop for one cycle
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we_i = 1'b0;
      adr = {27'd0, REG_IRQ_STAT, 2'b00}; sel_i = 4'hF;
      @(posedge clk);
      #1 chk("hold_ack1", {31'd0, ack}, 32'd1);
      chk("hold_dat1", dat_o, 32'h20);
      @(posedge clk);
      #1 chk("hold_ack_gap", {31'd0, ack}, 32'd0);
      chk("hold_dat_gap", dat_o, 32'd0);
      @(posedge clk);
      #1 chk("hold_ack2", {31'd0, ack}, 32'd1);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0;

      // Reset asserted during a pending write
      io_in = 16'h0000;
      repeat (IN_LAT + 2) @(posedge clk);
      wr(REG_OUT, 32'h55, 4'hF);
      wr(REG_OE, 32'hF0, 4'hF);
      wr(REG_IRQ_EN, 32'h1, 4'hF);
      wr(REG_EDGE, 32'h1, 4'hF);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we_i = 1'b1;
      adr = {27'd0, REG_OUT, 2'b00}; dat_i = 32'hFFFF; sel_i = 4'hF;
      rst = 1'b1;
      @(posedge clk);
      #1 chk("abort_no_ack", {31'd0, ack}, 32'd0);
      @(negedge clk);
      cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
      @(posedge clk);
      #1 chk("abort_ack_low", {31'd0, ack}, 32'd0);
      chk("abort_io_out", {16'd0, io_out}, 32'h0);
      chk("abort_io_oeb", {16'd0, io_oeb}, 32'h0000FFFF);
      chk("abort_irq", {29'd0, irq}, 32'd0);
      chk("abort_dat_o", dat_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("abort_out", REG_OUT, 32'h0);
      rd_chk("abort_oe", REG_OE, 32'h0);
      rd_chk("abort_irq_en", REG_IRQ_EN, 32'h0);
      rd_chk("abort_stat", REG_IRQ_STAT, 32'h0);
      rd_chk("abort_edge", REG_EDGE, 32'h0);

`ifdef GPIO_DEBOUNCE_EN
      // Three-cycle glitch is filtered, four stable cycles pass
      @(negedge clk);
      io_in[0] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      io_in[0] = 1'b0;
      repeat (12) @(posedge clk);
      rd_chk("deb_glitch", REG_IN, 32'h0);
      @(negedge clk);
      io_in[0] = 1'b1;
      repeat (IN_LAT + 2) @(posedge clk);
      rd_chk("deb_stable", REG_IN, 32'h1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
